vec_fetch: RTL and testbench
============================

VEC_FETCH -- requirements
Module: vec_fetch

Interface
REQ-001 SHALL have parameter DATA, default 16, meaning the RAM word width; legal values are DATA >= 4.
REQ-002 SHALL have parameter ADDR, default 10, meaning the RAM address width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the output FIFO entry count; legal values are powers of 2, >= 2.
REQ-004 SHALL have parameter HALT_OP, default 3'b001, meaning the opcode in word bits [DATA-1:DATA-3] that ends a list.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, meaning reset; it is asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit, meaning a request to begin a list fetch at start_addr.
REQ-008 SHALL have port start_addr, input, ADDR bits, meaning the first word address.
REQ-009 SHALL have port abort, input, 1 bit, meaning a synchronous cancel of the current list.
REQ-010 SHALL have port ram_addr, output, ADDR bits, meaning the address to the single-port RAM; the RAM read data is registered and valid one cycle after the address.
REQ-011 SHALL have port ram_dout, input, DATA bits, meaning the read data returned by the RAM.
REQ-012 SHALL have port out_valid, output, 1 bit, meaning the output word is valid.
REQ-013 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the output word.
REQ-014 SHALL have port out_data, output, DATA bits, meaning the fetched word.
REQ-015 SHALL have port out_last, output, 1 bit, meaning out_data is the HALT word.
REQ-016 SHALL have port busy, output, 1 bit, meaning the block is not in IDLE.
REQ-017 SHALL have port done, output, 1 bit, meaning a one-cycle pulse when a list completes normally.

Function
REQ-018 SHALL implement the states IDLE, FETCH and DRAIN.
REQ-019 SHALL, in IDLE with start=1, load ram_addr<=start_addr and enter FETCH; start SHALL be ignored outside IDLE.
REQ-020 SHALL treat a read as issued in every FETCH cycle in which occupancy + pending < DEPTH.
- occupancy: number of FIFO entries.
- pending: a read issued in the previous cycle.
- On issue: ram_addr increments next cycle, modulo 2^ADDR (2^ADDR-1 wraps to 0).
- Without issue: ram_addr holds.
REQ-021 SHALL push ram_dout into the FIFO on the cycle after each issue, unless that read is discarded.
REQ-022 SHALL set out_last on a pushed entry iff ram_dout[DATA-1:DATA-3]==HALT_OP.
- On that push: stop issuing, discard the one read still pending, enter DRAIN.
REQ-023 SHALL give a latency where start sampled at edge k produces out_valid=1 with mem[start_addr] after edge k+2.
REQ-024 SHALL sustain one word per cycle with out_ready held at 1.
REQ-025 SHALL keep out_valid=1 and out_data/out_last stable until out_ready=1; pop occurs on out_valid&out_ready.
REQ-026 SHALL allow push and pop in the same cycle; occupancy is then unchanged.
REQ-027 SHALL never push when full; the credit rule guarantees this, and a push to a full FIFO is an assertion failure.
REQ-028 SHALL, in DRAIN, when the out_last entry is popped, return to IDLE and pulse done=1 for exactly one cycle.
REQ-029 SHALL, on abort=1 in FETCH or DRAIN, respond next cycle as follows:
- flush the FIFO and drop the pending read;
- out_valid=0, state IDLE, no done pulse;
- abort in IDLE has no effect;
- abort takes priority over a simultaneous pop or HALT push.
REQ-030 SHALL drive busy=1 exactly in FETCH and DRAIN.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force the following:
- state IDLE, ram_addr=0;
- out_valid=0, out_data=0, out_last=0;
- busy=0, done=0;
- occupancy=0, pending=0.
REQ-032 SHALL, on reset mid-list, lose all fetched words; the first edge after release behaves as IDLE.

Verification
REQ-033 SHALL cover list at 0x010 = {0x2000? no-HALT words 0x4001,0x4002, HALT 0x2000}, out_ready=1, start at edge k:
- out_valid after edge k+2;
- words 0x4001,0x4002,0x2000 on consecutive cycles;
- out_last only on 0x2000;
- done pulses once.
REQ-034 SHALL cover out_ready=0 for 10 cycles during a long list:
- occupancy saturates at DEPTH=4 with no overflow and no word lost;
- ram_addr advances by exactly 4 (one pending read included) before stalling.
REQ-035 SHALL cover start_addr=0x3FE with words at 0x3FE, 0x3FF, 0x000(HALT): ram_addr wraps to 0x000 and three words are delivered in order.
REQ-036 SHALL cover abort asserted with 3 words queued and out_ready=1 in the same cycle: out_valid=0 and busy=0 on the next cycle, and done is never pulsed.
REQ-037 SHALL cover start pulsed while busy: it is ignored and the current list completes unchanged.
REQ-038 SHALL cover rst_n=0 asserted asynchronously mid-FETCH: outputs go to reset values before the next clock edge, and a new start after release fetches correctly.

Source files
------------

// File: rtl/vec_fetch.sv
// vec_fetch: walks a command list in a single-port RAM (registered read,
// one cycle latency) starting at start_addr and streams each word out
// through a small FIFO with a valid/ready handshake. The word whose opcode
// field (top three bits) equals HALT_OP ends the list and is flagged with
// out_last. Once that word has been consumed, done pulses for one cycle.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, start_addr     begin a list at start_addr (accepted in IDLE only)
//   abort                 cancel the current list, flush everything queued
//   ram_addr, ram_dout    RAM read address / data returned one cycle later
//   out_valid, out_ready  output handshake; pop on out_valid & out_ready
//   out_data, out_last    head FIFO word and its HALT flag
//   busy, done            not-IDLE indicator, one-cycle completion pulse
module vec_fetch #(
  parameter int         DATA    = 16,
  parameter int         ADDR    = 10,
  parameter int         DEPTH   = 4,
  parameter logic [2:0] HALT_OP = 3'b001
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [ADDR-1:0] start_addr,
  input  logic            abort,
  output logic [ADDR-1:0] ram_addr,
  input  logic [DATA-1:0] ram_dout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW:0]   LIMIT_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic            pending_q, pending_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            done_q, done_d;

  logic [DATA-1:0] fifo_data_q [DEPTH];
  logic            fifo_last_q [DEPTH];

  logic            kill;
  logic            issue;
  logic            push;
  logic            pop;
  logic            halt_hit;
  logic [CW:0]     credit_used;

  always_comb begin
    kill        = abort && (state_q != IDLE);
    pop         = (occ_q != '0) && out_ready;
    // A returning read is only kept while still fetching: in DRAIN it is
    // the speculative read issued alongside the HALT word and is dropped.
    push        = pending_q && (state_q == FETCH) && !kill;
    halt_hit    = push && (ram_dout[DATA-1 -: 3] == HALT_OP);
    // The in-flight read already owns a FIFO slot, so count it as used.
    credit_used = {1'b0, occ_q} + {{CW{1'b0}}, pending_q};
    issue       = (state_q == FETCH) && !kill && (credit_used < LIMIT_C);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pending_d = issue;
    occ_d     = occ_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    done_d    = 1'b0;

    if (issue) begin
      addr_d = addr_q + 1'b1;
    end

    if (kill) begin
      state_d  = IDLE;
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase

      case (state_q)
        IDLE: begin
          if (start) begin
            addr_d  = start_addr;
            state_d = FETCH;
          end
        end
        FETCH: begin
          if (halt_hit) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (pop && fifo_last_q[rd_ptr_q]) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      pending_q <= 1'b0;
      occ_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
      occ_q     <= occ_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      done_q    <= done_d;
    end
  end

  // Storage needs no reset: entries are only visible while occupancy > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ram_dout;
      fifo_last_q[wr_ptr_q] <= halt_hit;
    end
  end

  assign ram_addr  = addr_q;
  assign out_valid = (occ_q != '0);
  assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && fifo_last_q[rd_ptr_q];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // The credit check must make an overflowing push impossible.
  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (occ_q == FULL_C)));

endmodule

// File: tb/tb_vec_fetch.sv
module tb_vec_fetch;
  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  start_addr = '0;
  logic        abort = 1'b0;
  logic [9:0]  ram_addr;
  logic [15:0] ram_dout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] mem [1024];

  int vectors = 0;
  int miscompares = 0;

  // reference model state (updated once per cycle by the compare process)
  ent_t        exp_q[$];
  bit          act = 1'b0;
  int          lat = 0;
  bit          done_exp = 1'b0;
  bit          hold = 1'b0;
  bit          abort_chk = 1'b0;
  bit          was_act = 1'b0;
  logic [15:0] hold_data;
  logic        hold_last;
  logic [15:0] got[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          done_cnt = 0;
  bit          saw_addr0 = 1'b0;

  vec_fetch #(
    .DATA(16), .ADDR(10), .DEPTH(4), .HALT_OP(3'b001)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .abort(abort), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // single-port RAM with registered read
  always @(posedge clk) ram_dout <= mem[ram_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  // Expected stream: consecutive words from sa (mod 1024) up to and
  // including the first HALT word.
  function automatic void load_list(input logic [9:0] sa);
    logic [9:0] a = sa;
    ent_t e;
    for (int i = 0; i < 1024; i++) begin
      e.data = mem[a];
      e.last = (mem[a][15:13] == 3'b001);
      exp_q.push_back(e);
      if (e.last) break;
      a = a + 10'd1;
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (!rst_n) begin
      exp_q.delete();
      act = 1'b0; lat = 0; done_exp = 1'b0; hold = 1'b0; abort_chk = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(act));
      chk("done", 32'(done), 32'(done_exp));
      if (abort_chk) chk("abort_flush_valid", 32'(out_valid), 0);
      if (lat == 1 || lat == 2) chk("early_valid", 32'(out_valid), 0);
      if (lat == 3) chk("first_word_latency", 32'(out_valid), 1);
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(hold_data));
        chk("hold_last", 32'(out_last), 32'(hold_last));
      end
      if (out_valid) begin
        chk("word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("out_data", 32'(out_data), 32'(exp_q[0].data));
          chk("out_last", 32'(out_last), 32'(exp_q[0].last));
        end
      end
      if (busy && ram_addr == 10'd0) saw_addr0 = 1'b1;

      was_act = act; done_exp = 1'b0; hold = 1'b0; abort_chk = 1'b0;
      lat = (lat > 0 && lat < 3) ? lat + 1 : 0;
      if (abort && act) begin
        exp_q.delete();
        act = 1'b0; lat = 0; abort_chk = 1'b1;
      end else begin
        if (out_valid && out_ready) begin
          got.push_back(out_data);
          pop_cyc.push_back(cyc);
          if (exp_q.size() != 0) begin
            if (exp_q[0].last) begin
              act = 1'b0;
              done_exp = 1'b1;
            end
            void'(exp_q.pop_front());
          end
        end else if (out_valid) begin
          hold = 1'b1; hold_data = out_data; hold_last = out_last;
        end
        if (!was_act && start) begin
          act = 1'b1; lat = 1;
          load_list(start_addr);
        end
      end
    end
  end

  function automatic logic [15:0] nonhalt();
    logic [15:0] w = 16'($urandom);
    if (w[15:13] == 3'b001) w[15:13] = 3'b011;
    return w;
  endfunction

  function automatic logic [15:0] halt_word();
    logic [15:0] w = 16'($urandom);
    w[15:13] = 3'b001;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [9:0] a);
    start_addr = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, input bit rnd);
    int n = 0;
    while (act && n < budget) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 99) < 70);
        abort = ($urandom_range(0, 99) < 2);
        if ($urandom_range(0, 99) < 5) begin
          start = 1'b1;
          start_addr = 10'($urandom);
        end else begin
          start = 1'b0;
        end
      end
      tick();
      n++;
    end
    abort = 1'b0;
    start = 1'b0;
    chk({"list_finished_", name}, 32'(act), 0);
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
  endtask

  initial begin
    logic [15:0] basic_exp [3];
    int d0;
    logic [9:0] sa;
    int len;
    basic_exp[0] = 16'h4001; basic_exp[1] = 16'h4002; basic_exp[2] = 16'h2000;

    for (int i = 0; i < 1024; i++) mem[i] = nonhalt();

    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // basic list: latency, back-to-back words, single done
    mem[10'h010] = 16'h4001; mem[10'h011] = 16'h4002; mem[10'h012] = 16'h2000;
    got.delete(); pop_cyc.delete(); d0 = done_cnt; out_ready = 1'b1;
    kick(10'h010);
    wait_idle("basic", 50, 1'b0);
    chk("basic_count", got.size(), 3);
    if (got.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("basic_word", 32'(got[i]), 32'(basic_exp[i]));
      chk("basic_gap01", pop_cyc[1] - pop_cyc[0], 1);
      chk("basic_gap12", pop_cyc[2] - pop_cyc[1], 1);
    end
    chk("basic_done_once", done_cnt - d0, 1);

    // consumer stall: FIFO fills, fetch address stops 4 past start
    for (int i = 0; i < 40; i++) mem[10'h100 + i] = 16'h4000 + 16'(i);
    mem[10'h128] = 16'h2000;
    got.delete(); out_ready = 1'b0;
    kick(10'h100);
    repeat (11) tick();
    chk("stall_ram_addr", 32'(ram_addr), 32'h104);
    chk("stall_valid", 32'(out_valid), 1);
    chk("stall_head", 32'(out_data), 32'h4000);
    out_ready = 1'b1;
    wait_idle("stall", 200, 1'b0);
    chk("stall_count", got.size(), 41);
    if (got.size() == 41) begin
      chk("stall_word3", 32'(got[3]), 32'h4003);
      chk("stall_last_word", 32'(got[40]), 32'h2000);
    end

    // address wrap 0x3FE -> 0x3FF -> 0x000
    mem[10'h3FE] = 16'h5111; mem[10'h3FF] = 16'h5222; mem[10'h000] = 16'h3333;
    got.delete(); saw_addr0 = 1'b0; out_ready = 1'b1;
    kick(10'h3FE);
    wait_idle("wrap", 50, 1'b0);
    chk("wrap_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("wrap_w0", 32'(got[0]), 32'h5111);
      chk("wrap_w1", 32'(got[1]), 32'h5222);
      chk("wrap_w2", 32'(got[2]), 32'h3333);
    end
    chk("wrap_addr_zero_seen", 32'(saw_addr0), 1);

    // abort with three words queued and a pop requested in the same cycle
    for (int i = 0; i < 20; i++) mem[10'h180 + i] = 16'h6000 + 16'(i);
    mem[10'h194] = 16'h2194;
    got.delete(); d0 = done_cnt; out_ready = 1'b0;
    kick(10'h180);
    repeat (4) tick();
    chk("abort_pre_valid", 32'(out_valid), 1);
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (8) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_words", got.size(), 0);

    // start while busy is ignored
    for (int i = 0; i < 6; i++) mem[10'h200 + i] = 16'h7000 + 16'(i);
    mem[10'h206] = 16'h2207;
    mem[10'h300] = 16'h2300;
    got.delete(); d0 = done_cnt; out_ready = 1'b1;
    kick(10'h200);
    tick();
    start_addr = 10'h300; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("busy_start", 50, 1'b0);
    chk("busy_start_count", got.size(), 7);
    if (got.size() == 7) begin
      chk("busy_start_first", 32'(got[0]), 32'h7000);
      chk("busy_start_last", 32'(got[6]), 32'h2207);
    end
    chk("busy_start_done_once", done_cnt - d0, 1);

    // asynchronous reset in the middle of a fetch
    got.delete(); out_ready = 1'b1;
    kick(10'h100);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    got.delete(); d0 = done_cnt;
    kick(10'h010);
    wait_idle("after_reset", 50, 1'b0);
    chk("after_reset_count", got.size(), 3);
    if (got.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("after_reset_word", 32'(got[i]), 32'(basic_exp[i]));
    end
    chk("after_reset_done_once", done_cnt - d0, 1);

    // randomized lists with random backpressure, stray starts and aborts
    for (int t = 0; t < 25; t++) begin
      sa = 10'($urandom);
      len = $urandom_range(0, 10);
      for (int i = 0; i < len; i++) mem[10'(sa + 10'(i))] = nonhalt();
      mem[10'(sa + 10'(len))] = halt_word();
      kick(sa);
      wait_idle("random", 400, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
